rf_read_arbiter: RTL

//  Shares the single 32-bit 32:1 register-read mux (5-bit select) among NUM_REQ requesters.

---
 rtl/rf_read_arbiter_pkg.sv | 24 ++
 rtl/rf_read_arbiter_rr_pick.sv | 34 +++
 rtl/rf_read_arbiter.sv | 122 ++++++++++++
 3 files changed

// File: rtl/rf_read_arbiter_pkg.sv
// Shared constants, the pipeline-state view type and the onehot helper for the regfile read arbiter.
package rf_read_arbiter_pkg;

    localparam int RF_SEL_W    = 5;
    localparam int RF_DATA_W   = 32;
    localparam int RF_NUM_REGS = 32;
    localparam int MAX_REQ     = 8;

    // Occupancy of the two-stage read pipeline, derived from the stage valid bits.
    typedef enum logic [1:0] {
        PIPE_EMPTY  = 2'd0,
        PIPE_FILL   = 2'd1,
        PIPE_STREAM = 2'd2,
        PIPE_DRAIN  = 2'd3
    } pipe_state_t;

    function automatic logic [MAX_REQ-1:0] onehot(input logic [2:0] id);
        logic [MAX_REQ-1:0] oh;
        oh     = '0;
        oh[id] = 1'b1;
        return oh;
    endfunction

endpackage

// File: rtl/rf_read_arbiter_rr_pick.sv
// Combinational round-robin picker: scans from ptr upwards (wrapping) and grants the first request.
module rf_read_arbiter_rr_pick #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    ptr,
    output logic [NUM_REQ-1:0] grant_onehot,
    output logic [ID_W-1:0]    grant_id,
    output logic               any
);

    int idx;

    always_comb begin
        grant_onehot = '0;
        grant_id     = '0;
        any          = 1'b0;
        idx          = 0;
        // Walk from the farthest offset down so the closest requester to ptr is the last writer.
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            idx = int'(ptr) + i;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            if (req[idx]) begin
                grant_id = ID_W'(idx);
                any      = 1'b1;
            end
        end
        grant_onehot[grant_id] = any;
    end

endmodule

// File: rtl/rf_read_arbiter.sv
// Round-robin arbiter sharing one registered 32:1 register-read mux, fixed 2-cycle read latency.
// Optional write-to-read forwarding is enabled by defining RF_ARB_BYPASS_EN.
module rf_read_arbiter
    import rf_read_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = RF_DATA_W,
    parameter int SEL_W   = RF_SEL_W
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_REQ-1:0]       req_valid,
    input  logic [NUM_REQ*SEL_W-1:0] req_addr,
    output logic [NUM_REQ-1:0]       req_ready,
    output logic [SEL_W-1:0]         mux_sel,
    input  logic [DATA_W-1:0]        mux_data,
`ifdef RF_ARB_BYPASS_EN
    input  logic                     wr_en,
    input  logic [SEL_W-1:0]         wr_addr,
    input  logic [DATA_W-1:0]        wr_data,
`endif
    output logic [NUM_REQ-1:0]       rsp_valid,
    output logic [DATA_W-1:0]        rsp_data,
    output logic                     busy
);

    localparam int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [SEL_W-1:0]   addr_arr [NUM_REQ];
    logic [NUM_REQ-1:0] grant_onehot;
    logic [ID_W-1:0]    grant_id;
    logic               grant_any;
    logic [ID_W-1:0]    rr_ptr_reg;
    logic [ID_W-1:0]    s1_id_reg;
    logic [ID_W-1:0]    s2_id_reg;
    logic               s1_v_reg;
    logic               s2_v_reg;
    logic [DATA_W-1:0]  rd_data;
    logic [MAX_REQ-1:0] rsp_oh;
    pipe_state_t        pipe_state;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_addr
            assign addr_arr[gi] = req_addr[gi*SEL_W +: SEL_W];
        end
    endgenerate

    rf_read_arbiter_rr_pick #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_rr_pick (
        .req          (req_valid),
        .ptr          (rr_ptr_reg),
        .grant_onehot (grant_onehot),
        .grant_id     (grant_id),
        .any          (grant_any)
    );

    // Grants are suppressed while reset is asserted so nothing is accepted into a held pipeline.
    assign req_ready = grant_onehot & {NUM_REQ{rst_n}};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mux_sel    <= '0;
            s1_id_reg  <= '0;
            s1_v_reg   <= 1'b0;
            rr_ptr_reg <= '0;
        end else begin
            s1_v_reg <= grant_any;
            if (grant_any) begin
                mux_sel    <= addr_arr[grant_id];
                s1_id_reg  <= grant_id;
                rr_ptr_reg <= (grant_id == ID_W'(NUM_REQ - 1)) ? '0 : grant_id + 1'b1;
            end
        end
    end

`ifdef RF_ARB_BYPASS_EN
    // r0 is hardwired in the regfile, so a write to it must never shadow the mux value.
    always_comb begin
        rd_data = mux_data;
        if (wr_en && (wr_addr == mux_sel) && (wr_addr != '0)) begin
            rd_data = wr_data;
        end
    end
`else
    assign rd_data = mux_data;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_data  <= '0;
            s2_id_reg <= '0;
            s2_v_reg  <= 1'b0;
        end else begin
            s2_v_reg  <= s1_v_reg;
            s2_id_reg <= s1_id_reg;
            if (s1_v_reg) begin
                rsp_data <= rd_data;
            end
        end
    end

    always_comb begin
        rsp_oh    = onehot(3'(s2_id_reg));
        rsp_valid = s2_v_reg ? rsp_oh[NUM_REQ-1:0] : '0;
    end

    always_comb begin
        pipe_state = PIPE_EMPTY;
        case ({s1_v_reg, s2_v_reg})
            2'b10:   pipe_state = PIPE_FILL;
            2'b11:   pipe_state = PIPE_STREAM;
            2'b01:   pipe_state = PIPE_DRAIN;
            default: pipe_state = PIPE_EMPTY;
        endcase
    end

    assign busy = (pipe_state != PIPE_EMPTY);

endmodule
